// File: rtl/byte_ram_master.sv
// Command-driven master for a byte-wide synchronous RAM: single read/write,
// ascending block copy and block fill, one command in flight at a time.
module byte_ram_master #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmdValid,
  output logic              cmdReady,
  input  logic [1:0]        cmdOp,
  input  logic [ADDR_W-1:0] cmdAddr,
  input  logic [ADDR_W-1:0] cmdDst,
  input  logic [ADDR_W-1:0] cmdLen,
  input  logic [DATA_W-1:0] cmdData,
  output logic              rspValid,
  output logic [DATA_W-1:0] rspData,
  output logic              busy,
  output logic              ramEn,
  output logic              ramRw,
  output logic [ADDR_W-1:0] ramAddr,
  output logic [DATA_W-1:0] ramWdata,
  input  logic [DATA_W-1:0] ramRdata
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD     = 3'd1;
  localparam logic [2:0] RD_CAP = 3'd2;
  localparam logic [2:0] WR     = 3'd3;
  localparam logic [2:0] CP_RD  = 3'd4;
  localparam logic [2:0] CP_CAP = 3'd5;
  localparam logic [2:0] CP_WR  = 3'd6;
  localparam logic [2:0] FILL   = 3'd7;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_CP   = 2'b10;
  localparam logic [1:0] OP_FILL = 2'b11;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rsp_q, rsp_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    hold_d  = hold_q;
    rdata_d = rdata_q;
    rsp_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmdValid) begin
          addr_d = cmdAddr;
          dst_d  = cmdDst;
          cnt_d  = cmdLen;
          data_d = cmdData;
          // Zero-length copy/fill parks one cycle in FILL with writes gated off
          case (cmdOp)
            OP_RD:   state_d = RD;
            OP_WR:   state_d = WR;
            OP_CP:   state_d = (cmdLen == '0) ? FILL : CP_RD;
            OP_FILL: state_d = FILL;
            default: state_d = IDLE;
          endcase
        end
      end
      RD:     state_d = RD_CAP;
      RD_CAP: begin
        rdata_d = ramRdata;
        state_d = IDLE;
        rsp_d   = 1'b1;
      end
      WR: begin
        state_d = IDLE;
        rsp_d   = 1'b1;
      end
      CP_RD:  state_d = CP_CAP;
      CP_CAP: begin
        hold_d  = ramRdata;
        state_d = CP_WR;
      end
      CP_WR: begin
        addr_d = addr_q + ADDR_W'(1);
        dst_d  = dst_q + ADDR_W'(1);
        cnt_d  = cnt_q - ADDR_W'(1);
        if (cnt_q == ADDR_W'(1)) begin
          state_d = IDLE;
          rsp_d   = 1'b1;
        end else begin
          state_d = CP_RD;
        end
      end
      FILL: begin
        if (cnt_q != '0) begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - ADDR_W'(1);
        end
        if (cnt_q <= ADDR_W'(1)) begin
          state_d = IDLE;
          rsp_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      hold_q  <= '0;
      rdata_q <= '0;
      rsp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      rdata_q <= rdata_d;
      rsp_q   <= rsp_d;
    end
  end

  // RAM strobes decode straight from registered state, so reset silences them at once
  always_comb begin
    ramEn    = 1'b0;
    ramRw    = 1'b1;
    ramAddr  = '0;
    ramWdata = '0;
    case (state_q)
      RD, CP_RD: begin
        ramEn   = 1'b1;
        ramAddr = addr_q;
      end
      WR: begin
        ramEn    = 1'b1;
        ramRw    = 1'b0;
        ramAddr  = addr_q;
        ramWdata = data_q;
      end
      CP_WR: begin
        ramEn    = 1'b1;
        ramRw    = 1'b0;
        ramAddr  = dst_q;
        ramWdata = hold_q;
      end
      FILL: begin
        if (cnt_q != '0) begin
          ramEn    = 1'b1;
          ramRw    = 1'b0;
          ramAddr  = addr_q;
          ramWdata = data_q;
        end
      end
      default: ;
    endcase
  end

  assign cmdReady = reset && (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign rspValid = rsp_q;
  assign rspData  = rdata_q;

endmodule
